// File: rtl/dcache_miss_ctrl_if.sv
// Core / cache / memory signal bundle for the data-cache miss controller.
// The slave modport is the controller's view; the master modport is the
// view of whatever surrounds it (core, cache arrays and memory).
interface dcache_miss_ctrl_if #(
  parameter int BLOCK_SIZE = 128
);
  // core side
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [31:0]           req_addr_i;
  logic [31:0]           req_wdata_i;
  logic                  resp_valid_o;
  logic [31:0]           resp_rdata_o;
  // cache side
  logic                  c_r_en_o;
  logic [31:0]           c_r_addr_o;
  logic [31:0]           c_r_data_i;
  logic                  c_r_hit_i;
  logic                  c_w_en_o;
  logic [31:0]           c_w_addr_o;
  logic [31:0]           c_w_data_o;
  logic                  c_is_repair_o;
  logic [BLOCK_SIZE-1:0] c_repair_data_o;
  // memory side
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic                  mem_req_we_o;
  logic [31:0]           mem_req_addr_o;
  logic [31:0]           mem_req_wdata_o;
  logic                  mem_resp_valid_i;
  logic [31:0]           mem_resp_data_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o,
    input  c_r_data_i, c_r_hit_i,
    output c_r_en_o, c_r_addr_o, c_w_en_o, c_w_addr_o, c_w_data_o,
    output c_is_repair_o, c_repair_data_o,
    input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    output mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o,
    output c_r_data_i, c_r_hit_i,
    input  c_r_en_o, c_r_addr_o, c_w_en_o, c_w_addr_o, c_w_data_o,
    input  c_is_repair_o, c_repair_data_o,
    output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
    input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: one outstanding word request at a time.
// Loads look up the cache and refill a whole block from memory on a miss;
// stores are write-through without allocation. BLOCK_SIZE must be a power
// of two of at least 64 bits.
module dcache_miss_ctrl #(
  parameter int BLOCK_SIZE = 128
) (
  input  logic               clk,
  input  logic               rst,
  dcache_miss_ctrl_if.slave  bus
);

  localparam int WORDS = BLOCK_SIZE / 32;
  localparam int CNT_W = $clog2(WORDS);
  localparam int OFF_W = $clog2(BLOCK_SIZE / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_RD, MEM_WAIT, REFILL, MEM_WR, RESP
  } state_e;

  state_e            state_q, state_d;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       buf_q [WORDS];
  logic [31:0]       rdata_q;

  logic              accept;
  logic              beat;
  logic [CNT_W-1:0]  word_sel;

  assign accept   = (state_q == IDLE) && bus.req_valid_i;
  assign beat     = (state_q == MEM_WAIT) && bus.mem_resp_valid_i;
  assign word_sel = addr_q[OFF_W-1:2];

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and all handshake/cache/memory outputs.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d             = state_q;
    bus.req_ready_o     = 1'b0;
    bus.resp_valid_o    = 1'b0;
    bus.resp_rdata_o    = '0;
    bus.c_r_en_o        = 1'b0;
    bus.c_r_addr_o      = '0;
    bus.c_w_en_o        = 1'b0;
    bus.c_w_addr_o      = '0;
    bus.c_w_data_o      = '0;
    bus.c_is_repair_o   = 1'b0;
    bus.c_repair_data_o = '0;
    bus.mem_req_valid_o = 1'b0;
    bus.mem_req_we_o    = 1'b0;
    bus.mem_req_addr_o  = '0;
    bus.mem_req_wdata_o = '0;

    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (we_q) begin
          // Store probes with a plain write; the cache only updates on hit.
          bus.c_w_en_o   = 1'b1;
          bus.c_w_addr_o = addr_q;
          bus.c_w_data_o = wdata_q;
          state_d        = MEM_WR;
        end else begin
          bus.c_r_en_o   = 1'b1;
          bus.c_r_addr_o = addr_q;
          state_d        = bus.c_r_hit_i ? RESP : MEM_RD;
        end
      end
      MEM_RD: begin
        bus.mem_req_valid_o = 1'b1;
        bus.mem_req_addr_o  = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
        if (bus.mem_req_ready_i) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (beat && (cnt_q == LAST_BEAT)) state_d = REFILL;
      end
      REFILL: begin
        bus.c_w_en_o      = 1'b1;
        bus.c_is_repair_o = 1'b1;
        bus.c_w_addr_o    = addr_q;
        for (int i = 0; i < WORDS; i++) bus.c_repair_data_o[32*i +: 32] = buf_q[i];
        state_d = RESP;
      end
      MEM_WR: begin
        bus.mem_req_valid_o = 1'b1;
        bus.mem_req_we_o    = 1'b1;
        bus.mem_req_addr_o  = addr_q;
        bus.mem_req_wdata_o = wdata_q;
        if (bus.mem_req_ready_i) state_d = RESP;
      end
      RESP: begin
        bus.resp_valid_o = 1'b1;
        bus.resp_rdata_o = rdata_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, beat counter, refill buffer and load-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      // NOTE: the refill buffer is a small register array, not a RAM, so it
      // is cleared on reset like the rest of the datapath.
      for (int i = 0; i < WORDS; i++) buf_q[i] <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we_i;
        addr_q  <= bus.req_addr_i;
        wdata_q <= bus.req_wdata_i;
        rdata_q <= '0;  // stores respond with zero
      end
      if ((state_q == LOOKUP) && !we_q && bus.c_r_hit_i) rdata_q <= bus.c_r_data_i;
      if ((state_q == MEM_RD) && bus.mem_req_ready_i) cnt_q <= '0;
      if (beat) begin
        buf_q[cnt_q] <= bus.mem_resp_data_i;
        cnt_q        <= cnt_q + CNT_W'(1);
      end
      if (state_q == REFILL) rdata_q <= buf_q[word_sel];
    end
  end

endmodule

// File: doc/dcache_miss_ctrl.md
DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 128, giving cache block width in bits; WORDS = BLOCK_SIZE/32 = 4 at default.
REQ-002 SHALL have ports `clk` (input, 1) and `rst` (input, 1): single clock; reset asynchronous, active-low.
REQ-003 SHALL have core-side ports:
- `req_valid_i` (in, 1): request valid.
- `req_ready_o` (out, 1): request accepted when high with `req_valid_i`.
- `req_we_i` (in, 1): 1 = store, 0 = load.
- `req_addr_i` (in, 32): byte address.
- `req_wdata_i` (in, 32): store data.
- `resp_valid_o` (out, 1): one-cycle completion pulse.
- `resp_rdata_o` (out, 32): load data.
REQ-004 SHALL have cache-side ports:
- `c_r_en_o` (out, 1), `c_r_addr_o` (out, 32): cache read.
- `c_r_data_i` (in, 32), `c_r_hit_i` (in, 1): combinational cache read result.
- `c_w_en_o` (out, 1), `c_w_addr_o` (out, 32), `c_w_data_o` (out, 32): cache write.
- `c_is_repair_o` (out, 1): refill write.
- `c_repair_data_o` (out, BLOCK_SIZE): refill block.
REQ-005 SHALL have memory-side ports:
- `mem_req_valid_o` (out, 1), `mem_req_ready_i` (in, 1): request handshake.
- `mem_req_we_o` (out, 1), `mem_req_addr_o` (out, 32), `mem_req_wdata_o` (out, 32): request payload.
- `mem_resp_valid_i` (in, 1), `mem_resp_data_i` (in, 32): one read word per beat.

Function
REQ-006 SHALL implement FSM states IDLE, LOOKUP, MEM_RD, MEM_WAIT, REFILL, MEM_WR, RESP.
REQ-007 SHALL drive `req_ready_o` = 1 only in IDLE; on `req_valid_i` && `req_ready_o` it SHALL latch we/addr/wdata and go to LOOKUP.
REQ-008 In LOOKUP, for a load it SHALL drive `c_r_en_o` = 1 with the latched address and sample `c_r_hit_i`. On hit it SHALL register `c_r_data_i` and go to RESP. On miss it SHALL go to MEM_RD.
REQ-009 In LOOKUP, for a store it SHALL drive `c_w_en_o` = 1, `c_is_repair_o` = 0, and the latched addr/wdata for exactly one cycle, so the cache updates only on hit. It SHALL then go to MEM_WR (write-through, no write-allocate).
REQ-010 In MEM_RD it SHALL hold `mem_req_valid_o` = 1, `mem_req_we_o` = 0 and `mem_req_addr_o` = {addr[31:4], 4'b0} stable until `mem_req_ready_i` = 1, then go to MEM_WAIT with beat counter = 0.
REQ-011 In MEM_WAIT, each `mem_resp_valid_i` beat SHALL store `mem_resp_data_i` into refill buffer bits [32*cnt +: 32] and increment the 2-bit counter. After beat WORDS-1 it SHALL go to REFILL.
REQ-012 `mem_resp_valid_i` outside MEM_WAIT SHALL be ignored; gaps between beats SHALL be tolerated.
REQ-013 In REFILL it SHALL assert, for exactly one cycle:
- `c_w_en_o` = 1, `c_is_repair_o` = 1.
- `c_w_addr_o` = latched address.
- `c_repair_data_o` = refill buffer.
It SHALL register buffer word addr[3:2] as load data, then go to RESP.
REQ-014 In MEM_WR it SHALL hold `mem_req_valid_o` = 1, `mem_req_we_o` = 1 and the latched addr/wdata until `mem_req_ready_i`, then go to RESP.
REQ-015 In RESP it SHALL pulse `resp_valid_o` = 1 for one cycle with `resp_rdata_o` = load data (0 for stores), then go to IDLE.
REQ-016 `c_r_en_o`, `c_w_en_o`, `c_is_repair_o` and `mem_req_valid_o` SHALL be 0 in every state not named above.
REQ-017 Address bits [1:0] SHALL be ignored (word access only).
REQ-018 Latency from the accept cycle to `resp_valid_o`:
- Load hit: 2 cycles.
- Load miss: 2 + request wait + beat cycles + 1.
- Store: 2 + request wait.
REQ-019 At most one request SHALL be outstanding; no new request is accepted until RESP completes.

Reset
REQ-020 While `rst` = 0, the block SHALL asynchronously enter IDLE and clear:
- Beat counter.
- Latched request.
- Refill buffer.
- Load data.
REQ-021 Reset values SHALL be: `req_ready_o` = 1; `resp_rdata_o` = 0; all other outputs 0.
REQ-022 Reset during MEM_RD, MEM_WAIT or MEM_WR SHALL abandon the transaction, with no REFILL write and no response. Beats arriving after reset release SHALL be ignored.

Verification
REQ-023 Load hit: line preloaded at 0x100 with word1 = 0xDEADBEEF; load 0x104 -> `resp_valid_o` 2 cycles after accept, `resp_rdata_o` = 0xDEADBEEF, `mem_req_valid_o` never asserted.
REQ-024 Load miss: load 0x2008; `mem_req_ready_i` delayed 3 cycles; beats 0x11, 0x22, 0x33, 0x44 with a 1-cycle gap after beat 2.
- Expect `mem_req_addr_o` = 0x2000.
- Expect one REFILL cycle with `c_repair_data_o` = {0x44, 0x33, 0x22, 0x11}.
- Expect `resp_rdata_o` = 0x33.
- A repeat load of 0x2008 then hits.
REQ-025 Store hit and miss: store 0xCAFEF00D to a resident and to a non-resident address.
- Both produce a memory write with that data and address, then one `resp_valid_o`.
- Only the resident line changes; no refill occurs.
REQ-026 Back-to-back: hold `req_valid_i` high for two loads -> `req_ready_o` low from accept until after RESP; second request accepted on the first IDLE cycle.
REQ-027 Reset mid-refill: assert `rst` = 0 after beat 2, release, then send 2 stray beats.
- No repair write, no `resp_valid_o`.
- FSM in IDLE with `req_ready_o` = 1.
- Next miss collects exactly 4 fresh beats.
